// File: rtl/i2c_pkg.sv
// Shared I2C definitions: default byte width and pointer sizing helper,
// so every I2C block sizes its byte pointers the same way.
package i2c_pkg;

  localparam int I2C_WIDTH = 8;

  // Pointer width for a bank of n entries, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_byte_reg.sv
// One captured byte: asynchronous clear, synchronous load enable.
module i2c_byte_reg
  import i2c_pkg::*;
#(
  parameter int WIDTH = I2C_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the byte until the bank selects this slot for a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/i2c_addr_reg_bank.sv
// Multi-byte address capture bank for the I2C slave, clocked on SCL.
// Bytes are written in arrival order through an auto-incrementing pointer;
// byte 0 lands in the MSBs of addr_o.
//
// Strobe semantics: load_i is a single-cycle byte strobe with no back-pressure.
// Each SCL edge with load_i=1 presents exactly one byte on data_i; the bank
// either accepts it (writes byte[ptr]) or, when full with WRAP=0, drops it and
// raises the sticky ovf_o. start_i takes priority over load_i in the same cycle.
module i2c_addr_reg_bank
  import i2c_pkg::*;
#(
  parameter int WIDTH     = I2C_WIDTH,
  parameter int NUM_BYTES = 2,
  parameter bit WRAP      = 1'b0
) (
  input  logic                          SCL,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          load_i,
  input  logic [WIDTH-1:0]              data_i,
  output logic [NUM_BYTES*WIDTH-1:0]    addr_o,
  output logic [ptr_w(NUM_BYTES)-1:0]   ptr_o,
  output logic                          full_o,
  output logic                          ovf_o
);

  localparam int                PTR_W = ptr_w(NUM_BYTES);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(NUM_BYTES - 1);

  logic [PTR_W-1:0] ptr_q;
  logic             full_q;
  logic             ovf_q;
  logic             accept;
  logic [WIDTH-1:0] bytes [NUM_BYTES];

  // A load is written unless start_i overrides it or a saturated bank drops it.
  assign accept = load_i & ~start_i & (~full_q | WRAP);

  // Pointer and status flags; start_i restarts the frame but keeps byte contents.
  always_ff @(posedge SCL or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_i) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_i) begin
      if (full_q && !WRAP) begin
        ovf_q <= 1'b1;
      end else if (ptr_q == LAST) begin
        ptr_q  <= '0;
        full_q <= 1'b1;
      end else begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    i2c_byte_reg #(
      .WIDTH (WIDTH)
    ) u_byte (
      .clk   (SCL),
      .rst_n (rst_n),
      .en    (accept && (ptr_q == PTR_W'(i))),
      .d     (data_i),
      .q     (bytes[i])
    );
    assign addr_o[(NUM_BYTES-1-i)*WIDTH +: WIDTH] = bytes[i];
  end

  assign ptr_o  = ptr_q;
  assign full_o = full_q;
  assign ovf_o  = ovf_q;

endmodule
